// File: rtl/cpu_spi_pkg.sv
// rtl/cpu_spi_pkg.sv - shared widths, opcodes and FSM state type for the SPI multiplier master
package cpu_spi_pkg;

  localparam int OP_W          = 4;
  localparam int DATA_W        = 32;
  localparam int FRAME_TX_BITS = 68;

  localparam logic [OP_W-1:0] OP_MUL = 4'b1001;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_TX,
    ST_TURN,
    ST_RX,
    ST_GAP
  } spi_master_state_t;

endpackage

// File: rtl/spi_sclk_gen.sv
// rtl/spi_sclk_gen.sv - SCLK generator: CLK_DIV clocks per half-period, ticks one cycle before each edge
module spi_sclk_gen #(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic clock_i,
  input  logic reset_ni,
  input  logic en_i,
  output logic sclk_o,
  output logic rise_tick_o,
  output logic fall_tick_o
);

  logic [15:0] cnt_q;
  logic        sclk_q;
  logic        last_d;

  assign last_d      = en_i && (cnt_q == 16'(CLK_DIV - 1));
  assign rise_tick_o = last_d && !sclk_q;
  assign fall_tick_o = last_d && sclk_q;
  assign sclk_o      = sclk_q;

  // Dropping enable parks SCLK low and restarts the half-period count.
  always_ff @(posedge clock_i or negedge reset_ni) begin
    if (!reset_ni) begin
      cnt_q  <= '0;
      sclk_q <= 1'b0;
    end else if (!en_i) begin
      cnt_q  <= '0;
      sclk_q <= 1'b0;
    end else if (last_d) begin
      cnt_q  <= '0;
      sclk_q <= ~sclk_q;
    end else begin
      cnt_q <= cnt_q + 16'd1;
    end
  end

endmodule

// File: rtl/spi_mul_master.sv
// rtl/spi_mul_master.sv - SPI master sending {opcode,A,B} and receiving a 32-bit product
// Optional abort port pair enabled by SPI_MUL_MASTER_ABORT_EN.
module spi_mul_master
  import cpu_spi_pkg::*;
#(
  parameter int unsigned CLK_DIV  = 4,
  parameter int unsigned TURN_CYC = 4,
  parameter int unsigned NSS_GAP  = 2
) (
  input  logic              clock_i,
  input  logic              reset_ni,
  input  logic              start_i,
  input  logic [OP_W-1:0]   opcode_i,
  input  logic [DATA_W-1:0] operand_a_i,
  input  logic [DATA_W-1:0] operand_b_i,
  output logic              ready_o,
  output logic [DATA_W-1:0] result_o,
  output logic              result_valid_o,
  output logic              sclk_o,
  output logic              mosi_o,
  output logic              nss_o,
  input  logic              miso_i
`ifdef SPI_MUL_MASTER_ABORT_EN
  ,
  input  logic              abort_i,
  output logic              aborted_o
`endif
);

  spi_master_state_t        state_q;
  logic [FRAME_TX_BITS-1:0] tx_q;
  logic [DATA_W-1:0]        rx_q;
  logic [DATA_W-1:0]        result_q;
  logic [6:0]               bit_cnt_q;
  logic [15:0]              cyc_q;
  logic                     nss_q;
  logic                     mosi_q;
  logic                     ready_q;
  logic                     valid_q;
  logic                     abort_d;
  logic                     sclk_en_d;
  logic                     rise_tick;
  logic                     fall_tick;

`ifdef SPI_MUL_MASTER_ABORT_EN
  logic aborted_q;
  assign abort_d   = abort_i && (state_q != ST_IDLE);
  assign aborted_o = aborted_q;
`else
  assign abort_d = 1'b0;
`endif

  // Abort must also kill SCLK on the very next edge, so it gates the enable directly.
  assign sclk_en_d = ((state_q == ST_TX) || (state_q == ST_RX)) && !abort_d;

  spi_sclk_gen #(
    .CLK_DIV(CLK_DIV)
  ) u_sclk_gen (
    .clock_i    (clock_i),
    .reset_ni   (reset_ni),
    .en_i       (sclk_en_d),
    .sclk_o     (sclk_o),
    .rise_tick_o(rise_tick),
    .fall_tick_o(fall_tick)
  );

  always_ff @(posedge clock_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q   <= ST_IDLE;
      tx_q      <= '0;
      rx_q      <= '0;
      result_q  <= '0;
      bit_cnt_q <= '0;
      cyc_q     <= '0;
      nss_q     <= 1'b1;
      mosi_q    <= 1'b0;
      ready_q   <= 1'b1;
      valid_q   <= 1'b0;
`ifdef SPI_MUL_MASTER_ABORT_EN
      aborted_q <= 1'b0;
`endif
    end else begin
      valid_q <= 1'b0;
`ifdef SPI_MUL_MASTER_ABORT_EN
      aborted_q <= 1'b0;
`endif
      if (abort_d) begin
        state_q   <= ST_GAP;
        nss_q     <= 1'b1;
        mosi_q    <= 1'b0;
        cyc_q     <= '0;
        bit_cnt_q <= '0;
`ifdef SPI_MUL_MASTER_ABORT_EN
        aborted_q <= 1'b1;
`endif
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (start_i) begin
              tx_q    <= {opcode_i, operand_a_i, operand_b_i};
              ready_q <= 1'b0;
              state_q <= ST_LOAD;
            end
          end
          ST_LOAD: begin
            nss_q     <= 1'b0;
            bit_cnt_q <= '0;
            mosi_q    <= tx_q[FRAME_TX_BITS-1];
            tx_q      <= {tx_q[FRAME_TX_BITS-2:0], 1'b0};
            state_q   <= ST_TX;
          end
          ST_TX: begin
            if (rise_tick) begin
              bit_cnt_q <= bit_cnt_q + 7'd1;
            end
            // MOSI only moves on the falling edge; the fall after the last rise ends the phase.
            if (fall_tick) begin
              if (bit_cnt_q == 7'(FRAME_TX_BITS)) begin
                mosi_q    <= 1'b0;
                bit_cnt_q <= '0;
                cyc_q     <= '0;
                state_q   <= ST_TURN;
              end else begin
                mosi_q <= tx_q[FRAME_TX_BITS-1];
                tx_q   <= {tx_q[FRAME_TX_BITS-2:0], 1'b0};
              end
            end
          end
          ST_TURN: begin
            if (cyc_q == 16'(TURN_CYC - 1)) begin
              state_q <= ST_RX;
            end else begin
              cyc_q <= cyc_q + 16'd1;
            end
          end
          ST_RX: begin
            if (rise_tick) begin
              rx_q      <= {rx_q[DATA_W-2:0], miso_i};
              bit_cnt_q <= bit_cnt_q + 7'd1;
            end
            if (fall_tick && (bit_cnt_q == 7'(DATA_W))) begin
              result_q  <= rx_q;
              valid_q   <= 1'b1;
              nss_q     <= 1'b1;
              bit_cnt_q <= '0;
              cyc_q     <= '0;
              state_q   <= ST_GAP;
            end
          end
          ST_GAP: begin
            if (cyc_q == 16'(NSS_GAP - 1)) begin
              ready_q <= 1'b1;
              state_q <= ST_IDLE;
            end else begin
              cyc_q <= cyc_q + 16'd1;
            end
          end
          default: begin
            state_q <= ST_IDLE;
          end
        endcase
      end
    end
  end

  assign ready_o        = ready_q;
  assign result_o       = result_q;
  assign result_valid_o = valid_q;
  assign mosi_o         = mosi_q;
  assign nss_o          = nss_q;

endmodule
